// File: rtl/i2c_target.sv
// I2C target with glitch-filtered SCL/SDA, 7-bit address match and an 8-bit register port.
// A write sends a pointer byte and then data bytes; a read returns data starting at the pointer.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h40,
    parameter int         FILTER_LEN  = 3,
    parameter bit         AUTO_INC    = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o
);
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG_ID, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    // Input path: bit 0 carries SCL, bit 1 carries SDA
    logic [1:0]       sync_p0, sync_p1, filt_p2, filt_p3;
    logic [CNT_W-1:0] stab_cnt [2];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_p0     <= 2'b11;
            sync_p1     <= 2'b11;
            filt_p2     <= 2'b11;
            filt_p3     <= 2'b11;
            stab_cnt[0] <= '0;
            stab_cnt[1] <= '0;
        end else begin
            sync_p0 <= {sda_i, scl_i};
            sync_p1 <= sync_p0;
            filt_p3 <= filt_p2;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == filt_p2[i]) begin
                    stab_cnt[i] <= '0;
                end else if (stab_cnt[i] == CNT_W'(FILTER_LEN - 1)) begin
                    filt_p2[i]  <= sync_p1[i];
                    stab_cnt[i] <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Bus event decode on the filtered levels
    logic scl_f, sda_f, scl_q, sda_q;
    logic ev_start, ev_stop, ev_rise, ev_fall;

    assign {sda_f, scl_f} = filt_p2;
    assign {sda_q, scl_q} = filt_p3;
    assign ev_start = scl_f & scl_q & sda_q & ~sda_f;
    assign ev_stop  = scl_f & scl_q & ~sda_q & sda_f;
    assign ev_rise  = scl_f & ~scl_q;
    assign ev_fall  = ~scl_f & scl_q;

    state_t     state;
    logic [7:0] shreg;
    logic [7:0] rx_byte;
    logic [3:0] bit_cnt;
    logic       rw;
    logic       ack_on;

    assign rx_byte = {shreg[6:0], sda_f};

    // Protocol FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            rw          <= 1'b0;
            ack_on      <= 1'b0;
            sda_oe_o    <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_we_o    <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            reg_we_o <= 1'b0;
            if (reg_we_o && AUTO_INC)
                reg_addr_o <= reg_addr_o + 8'd1;

            if (ev_start) begin
                bit_cnt  <= '0;
                ack_on   <= 1'b0;
                sda_oe_o <= 1'b0;
                state    <= ADDR;
            end else if (ev_stop) begin
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: if (ev_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (rx_byte[7:1] == TARGET_ADDR) begin
                                rw     <= rx_byte[0];
                                ack_on <= 1'b0;
                                state  <= ADDR_ACK;
                            end else begin
                                busy_o <= 1'b0;
                                state  <= IGNORE;
                            end
                        end
                    end
                    // First fall drives the ACK, second fall ends the ACK clock
                    ADDR_ACK: if (ev_fall) begin
                        if (!ack_on) begin
                            sda_oe_o <= 1'b1;
                            busy_o   <= 1'b1;
                            ack_on   <= 1'b1;
                        end else begin
                            ack_on  <= 1'b0;
                            bit_cnt <= '0;
                            if (rw) begin
                                shreg    <= {reg_rdata_i[6:0], 1'b0};
                                sda_oe_o <= ~reg_rdata_i[7];
                                state    <= RD_DATA;
                            end else begin
                                sda_oe_o <= 1'b0;
                                state    <= REG_ID;
                            end
                        end
                    end
                    REG_ID, WR_DATA: if (ev_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (state == REG_ID) begin
                                reg_addr_o <= rx_byte;
                            end else begin
                                reg_wdata_o <= rx_byte;
                                reg_we_o    <= 1'b1;
                            end
                            ack_on <= 1'b0;
                            state  <= WR_ACK;
                        end
                    end
                    WR_ACK: if (ev_fall) begin
                        if (!ack_on) begin
                            sda_oe_o <= 1'b1;
                            ack_on   <= 1'b1;
                        end else begin
                            sda_oe_o <= 1'b0;
                            ack_on   <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= WR_DATA;
                        end
                    end
                    // bit_cnt counts bits the controller has sampled; the MSB went out at load
                    RD_DATA: if (ev_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (ev_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_o <= 1'b0;
                            state    <= RD_ACK;
                        end else begin
                            sda_oe_o <= ~shreg[7];
                            shreg    <= {shreg[6:0], 1'b0};
                        end
                    end
                    // A fall here can only follow an ACK; a NACK has already left
                    RD_ACK: if (ev_rise) begin
                        if (AUTO_INC)
                            reg_addr_o <= reg_addr_o + 8'd1;
                        if (sda_f)
                            state <= IGNORE;
                    end else if (ev_fall) begin
                        shreg    <= {reg_rdata_i[6:0], 1'b0};
                        sda_oe_o <= ~reg_rdata_i[7];
                        bit_cnt  <= '0;
                        state    <= RD_DATA;
                    end
                    IGNORE: sda_oe_o <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level I2C controller tasks, a pointer/register model per target,
// and a per-cycle strobe and SDA-timing check on two targets sharing one bus.
module tb_i2c_target;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic [1:0] oe, we, busy;
    logic [7:0] raddr [2];
    logic [7:0] wdata [2];
    logic [7:0] rdata [2];

    assign sda_bus  = sda_m & ~oe[0] & ~oe[1];
    assign rdata[0] = raddr[0] ^ 8'hA5;
    assign rdata[1] = raddr[1] ^ 8'hA5;

    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(7'h40), .FILTER_LEN(3), .AUTO_INC(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe_o(oe[0]),
        .reg_addr_o(raddr[0]), .reg_wdata_o(wdata[0]), .reg_we_o(we[0]),
        .reg_rdata_i(rdata[0]), .busy_o(busy[0]));

    i2c_target #(.TARGET_ADDR(7'h41), .FILTER_LEN(3), .AUTO_INC(1'b0)) dut_ni (
        .clk_i(clk), .rst_i(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe_o(oe[1]),
        .reg_addr_o(raddr[1]), .reg_wdata_o(wdata[1]), .reg_we_o(we[1]),
        .reg_rdata_i(rdata[1]), .busy_o(busy[1]));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: per-target pointer and the write strobes it must see, in order
    logic [7:0]  mptr [2];
    int          minc [2] = '{1, 0};
    logic [15:0] exp0[$], exp1[$];
    logic [15:0] log0[$], log1[$];
    logic [7:0]  rd_last [4];
    logic [7:0]  wbuf [4];
    int          widx0 = 0, widx1 = 0;
    int          oe_hi_cycles = 0;
    logic [1:0]  oe_q = 2'b00;

    function automatic int tgt_of(input logic [6:0] a);
        if (a == 7'h40) return 0;
        if (a == 7'h41) return 1;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (we[0]) begin
                log0.push_back({raddr[0], wdata[0]});
                check("strobe0_expected", widx0 < exp0.size(), 1);
                if (widx0 < exp0.size()) begin
                    check("strobe0", {raddr[0], wdata[0]}, exp0[widx0]);
                    widx0++;
                end
            end
            if (we[1]) begin
                log1.push_back({raddr[1], wdata[1]});
                check("strobe1_expected", widx1 < exp1.size(), 1);
                if (widx1 < exp1.size()) begin
                    check("strobe1", {raddr[1], wdata[1]}, exp1[widx1]);
                    widx1++;
                end
            end
            for (int i = 0; i < 2; i++)
                if (oe[i] != oe_q[i]) check("oe_change_scl_low", scl_m, 0);
        end
        if (|oe) oe_hi_cycles++;
        oe_q <= oe;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b, output logic got);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        got = sda_bus; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic g;
        for (int i = 7; i >= 0; i--) send_bit(b[i], g);
        send_bit(1'b1, g);
        ack = ~g;
    endtask

    task automatic recv_byte(input logic ackbit, output logic [7:0] b);
        logic g;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, g);
            b[i] = g;
        end
        send_bit(ackbit, g);
    endtask

    task automatic post_checks(input int t);
        wait_clk(8);
        check("busy0_after_stop", busy[0], 0);
        check("busy1_after_stop", busy[1], 0);
        if (t >= 0) check("ptr_after_stop", raddr[t], mptr[t]);
    endtask

    task automatic xfer_write(input logic [6:0] a, input logic [7:0] p, input int n);
        int t;
        logic ack;
        t = tgt_of(a);
        bus_start();
        send_byte({a, 1'b0}, ack);
        check("wr_addr_ack", ack, t >= 0);
        if (t >= 0) begin
            send_byte(p, ack);
            check("ptr_ack", ack, 1);
            check("busy_in_xfer", busy[t], 1);
            mptr[t] = p;
            for (int i = 0; i < n; i++) begin
                if (t == 0) exp0.push_back({mptr[t], wbuf[i]});
                else        exp1.push_back({mptr[t], wbuf[i]});
                send_byte(wbuf[i], ack);
                check("data_ack", ack, 1);
                mptr[t] = mptr[t] + 8'(minc[t]);
            end
        end
        bus_stop();
        post_checks(t);
    endtask

    task automatic xfer_read(input logic [6:0] a, input logic [7:0] p, input int n);
        int t;
        logic ack;
        logic [7:0] b;
        t = tgt_of(a);
        bus_start();
        send_byte({a, 1'b0}, ack);
        check("rd_addr_ack", ack, t >= 0);
        if (t >= 0) begin
            send_byte(p, ack);
            check("rd_ptr_ack", ack, 1);
            mptr[t] = p;
            bus_start();
            send_byte({a, 1'b1}, ack);
            check("rd_addr_r_ack", ack, 1);
            for (int i = 0; i < n; i++) begin
                recv_byte(i == n - 1, b);
                rd_last[i] = b;
                check("rd_byte", b, mptr[t] ^ 8'hA5);
                mptr[t] = mptr[t] + 8'(minc[t]);
            end
        end
        bus_stop();
        post_checks(t);
    endtask

    initial begin
        #(1_500_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, hi0;
        logic ack, g;
        logic [7:0] abyte;
        mptr[0] = 8'h00;
        mptr[1] = 8'h00;

        wait_clk(5);
        for (int i = 0; i < 2; i++) begin
            check("rst_oe", oe[i], 0);
            check("rst_addr", raddr[i], 0);
            check("rst_wdata", wdata[i], 0);
            check("rst_we", we[i], 0);
            check("rst_busy", busy[i], 0);
        end
        rst = 1'b0;
        wait_clk(10);

        // Write 0x12, 0x34 starting at pointer 0x06
        wbuf[0] = 8'h12; wbuf[1] = 8'h34;
        xfer_write(7'h40, 8'h06, 2);
        check("t1_strobe_count", log0.size(), 2);
        check("t1_strobe_a", log0[0], 16'h0612);
        check("t1_strobe_b", log0[1], 16'h0734);
        check("t1_end_ptr", raddr[0], 8'h08);

        // Read two bytes from pointer 0x10 via repeated start
        b0 = log0.size();
        xfer_read(7'h40, 8'h10, 2);
        check("t2_byte0", rd_last[0], 8'hB5);
        check("t2_byte1", rd_last[1], 8'hB4);
        check("t2_end_ptr", raddr[0], 8'h12);
        check("t2_no_strobe", log0.size(), b0);

        // Foreign address: nobody drives SDA
        hi0 = oe_hi_cycles;
        wbuf[0] = 8'h99;
        xfer_write(7'h21, 8'h00, 1);
        check("t3_sda_never_driven", oe_hi_cycles, hi0);
        wbuf[0] = 8'h5C;
        xfer_write(7'h40, 8'h50, 1);

        // Pointer wrap on the incrementing target, hold on the other
        b0 = log0.size();
        b1 = log1.size();
        wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
        xfer_write(7'h40, 8'hFF, 2);
        xfer_write(7'h41, 8'hFF, 2);
        check("t4_wrap_a", log0[b0], 16'hFFAA);
        check("t4_wrap_b", log0[b0 + 1], 16'h00BB);
        check("t4_hold_a", log1[b1], 16'hFFAA);
        check("t4_hold_b", log1[b1 + 1], 16'hFFBB);

        // Data byte cut short by STOP, then 2-clk glitches on an idle bus
        bus_start();
        send_byte(8'h80, ack); check("t5_addr_ack", ack, 1);
        send_byte(8'h20, ack); check("t5_ptr_ack", ack, 1);
        mptr[0] = 8'h20;
        exp0.push_back({8'h20, 8'h77});
        send_byte(8'h77, ack); check("t5_data_ack", ack, 1);
        mptr[0] = mptr[0] + 8'd1;
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), g);
        bus_stop();
        post_checks(0);
        sda_m = 1'b0; wait_clk(2); sda_m = 1'b1; wait_clk(20);
        scl_m = 1'b0; wait_clk(2); scl_m = 1'b1; wait_clk(20);
        scl_m = 1'b0; wait_clk(Q);
        send_byte(8'h80, ack);
        check("t5_no_false_start", ack, 0);
        bus_stop();
        post_checks(0);

        // Reset while the target is driving the address ACK
        abyte = 8'h80;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(abyte[i], g);
        check("t6_ack_driven", oe[0], 1);
        check("t6_busy_set", busy[0], 1);
        #2 rst = 1'b1;
        #1 check("t6_oe_async_release", oe[0], 0);
        wait_clk(3);
        check("t6_rst_addr", raddr[0], 0);
        check("t6_rst_wdata", wdata[0], 0);
        check("t6_rst_we", we[0], 0);
        check("t6_rst_busy", busy[0], 0);
        rst = 1'b0;
        mptr[0] = 8'h00;
        mptr[1] = 8'h00;
        wait_clk(4);
        bus_stop();
        wait_clk(10);
        wbuf[0] = 8'h5A;
        xfer_write(7'h40, 8'h33, 1);

        // Randomised traffic against the model
        for (int k = 0; k < 12; k++) begin
            int sel, n;
            logic [6:0] a;
            logic [7:0] p;
            sel = $urandom_range(0, 4);
            a = (sel < 2) ? 7'h40 : (sel < 4) ? 7'h41 : 7'($urandom_range(0, 127));
            p = 8'($urandom);
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) xfer_write(a, p, n);
            else                           xfer_read(a, p, n);
        end

        wait_clk(10);
        check("all_strobes_seen0", widx0, exp0.size());
        check("all_strobes_seen1", widx1, exp1.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
